pr_icap_wr: RTL

Write-side engine of the partial-reconfiguration path. It accepts the bitstream as a 32-bit AXI4-Stream in the ICAP clock domain, bit-swaps each byte and drives the ICAPE3 write port. It checks the word count against a programmed length and flags each written word to the PR completion detector via `pr_val`/`pr_last`. It sits between the PR bitstream FIFO and the ICAP primitive.

---
 rtl/pr_icap_wr_pkg.sv | 26 ++
 rtl/pr_icap_wr_if.sv | 25 ++
 rtl/pr_icap_wr.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pr_icap_wr_pkg.sv
// Shared types and helpers for the partial-reconfiguration ICAP path.
// The bit-swap function is also meant for a future readback engine.
package pr_icap_wr_pkg;

    localparam int PR_ICAP_BITS = 32;

    typedef enum logic [1:0] {
        PR_ST_IDLE   = 2'd0,
        PR_ST_STREAM = 2'd1,
        PR_ST_FLUSH  = 2'd2,
        PR_ST_DONE   = 2'd3
    } pr_state_e;

    // ICAPE3 expects each byte with its bit order reversed; byte order is kept.
    function automatic logic [PR_ICAP_BITS-1:0] icap_bitswap(input logic [PR_ICAP_BITS-1:0] d);
        logic [PR_ICAP_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < PR_ICAP_BITS / 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*k + j] = d[8*k + 7 - j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pr_icap_wr_if.sv
// Bitstream AXI4-Stream input plus ICAPE3 write port, bundled as one bus.
interface pr_icap_wr_if;
    import pr_icap_wr_pkg::*;

    logic [PR_ICAP_BITS-1:0] s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tlast;
    logic                    s_axis_tready;
    logic [PR_ICAP_BITS-1:0] icap_i;
    logic                    icap_csib;
    logic                    icap_rdwrb;
    logic                    icap_avail;
    logic                    icap_prerror;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, icap_avail, icap_prerror,
        output s_axis_tready, icap_i, icap_csib, icap_rdwrb
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, icap_avail, icap_prerror,
        input  s_axis_tready, icap_i, icap_csib, icap_rdwrb
    );

endinterface

// File: rtl/pr_icap_wr.sv
// Write-side ICAP engine: streams a bit-swapped bitstream into ICAPE3,
// checks the word count against the programmed length and reports completion.
//
// state     | meaning
// ST_IDLE   | waiting for start, stream not accepted
// ST_STREAM | writing accepted words to ICAP
// ST_FLUSH  | draining the stream up to tlast after an error, nothing written
// ST_DONE   | clean completion, done pulse follows
module pr_icap_wr
    import pr_icap_wr_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int CNT_BITS  = 32
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                start,
    input  logic [CNT_BITS-1:0] pr_len,
    pr_icap_wr_if.slave         bus,
    output logic                pr_val,
    output logic                pr_last,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_BITS-1:0] wcnt
);

    localparam logic [1:0] ST_IDLE   = PR_ST_IDLE;
    localparam logic [1:0] ST_STREAM = PR_ST_STREAM;
    localparam logic [1:0] ST_FLUSH  = PR_ST_FLUSH;
    localparam logic [1:0] ST_DONE   = PR_ST_DONE;

    logic [1:0]           state;
    logic [CNT_BITS-1:0]  len_q;
    logic [CNT_BITS-1:0]  wcnt_q;
    logic                 err_q;
    logic                 tready;
    logic                 hs;
    logic                 wr;
    logic                 at_len;
    logic                 start_ok;
    logic                 start_zero;
    logic [DATA_BITS-1:0] swapped;
    logic [DATA_BITS-1:0] icap_q;
    logic                 csib_q;
    logic                 rdwrb_q;
    logic                 pr_val_q;
    logic                 pr_last_q;
    logic                 done_q;

    always_comb begin
        tready = 1'b0;
        case (state)
            ST_STREAM: tready = bus.icap_avail & ~bus.icap_prerror;
            ST_FLUSH:  tready = 1'b1;
            default:   tready = 1'b0;
        endcase
    end

    assign hs         = bus.s_axis_tvalid & tready;
    assign wr         = hs & (state == ST_STREAM);
    assign at_len     = (wcnt_q == len_q - CNT_BITS'(1));
    assign start_ok   = (state == ST_IDLE) & start & (pr_len != '0);
    assign start_zero = (state == ST_IDLE) & start & (pr_len == '0);
    assign swapped    = icap_bitswap(bus.s_axis_tdata);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_q  <= pr_len;
                        wcnt_q <= '0;
                        err_q  <= 1'b0;
                        state  <= ST_STREAM;
                    end else if (start_zero) begin
                        err_q <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (bus.icap_prerror) begin
                        err_q <= 1'b1;
                        state <= ST_FLUSH;
                    end else if (hs) begin
                        wcnt_q <= wcnt_q + CNT_BITS'(1);
                        if (bus.s_axis_tlast && at_len) begin
                            state <= ST_DONE;
                        end else if (bus.s_axis_tlast) begin
                            err_q <= 1'b1;
                            state <= ST_IDLE;
                        end else if (at_len) begin
                            err_q <= 1'b1;
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (hs && bus.s_axis_tlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Direction stays at write for one cycle past the last STREAM cycle so it
    // never toggles while chip select is still low.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            icap_q    <= '0;
            csib_q    <= 1'b1;
            rdwrb_q   <= 1'b1;
            pr_val_q  <= 1'b0;
            pr_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (wr) icap_q <= swapped;
            csib_q    <= ~wr;
            pr_val_q  <= wr;
            pr_last_q <= wr & bus.s_axis_tlast & at_len;
            rdwrb_q   <= ~(start_ok | (state == ST_STREAM));
            done_q    <= (state == ST_DONE);
        end
    end

    assign bus.s_axis_tready = tready;
    assign bus.icap_i        = icap_q;
    assign bus.icap_csib     = csib_q;
    assign bus.icap_rdwrb    = rdwrb_q;
    assign pr_val            = pr_val_q;
    assign pr_last           = pr_last_q;
    assign busy              = (state != ST_IDLE);
    assign done              = done_q;
    assign err               = err_q;
    assign wcnt              = wcnt_q;

endmodule
